// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit counters, trained from ID resolution.
// Define BTB_STATS_EN to add saturating hit/update statistics counters.
module branch_target_buffer #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] IF_pc,
    input  logic                 fetch_en,
    output logic [WORD_SIZE-1:0] predicted_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic                 ready,
    input  logic                 upd_en,
    input  logic [1:0]           upd_kind,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_taken,
    output logic [15:0]          stat_hits,
    output logic [15:0]          stat_updates
);

    localparam int N     = 1 << IDX_BITS;
    localparam int TAG_W = WORD_SIZE - IDX_BITS;
    localparam logic [WORD_SIZE-1:0] PC_ONE = 1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] sweep_q, sweep_d;
    logic                ready_q, ready_d;

    logic                valid_q  [N];
    logic                valid_d  [N];
    logic [TAG_W-1:0]    tag_q    [N];
    logic [TAG_W-1:0]    tag_d    [N];
    logic [WORD_SIZE-1:0] target_q [N];
    logic [WORD_SIZE-1:0] target_d [N];
    logic                uncond_q [N];
    logic                uncond_d [N];
    logic [1:0]          ctr_q    [N];
    logic [1:0]          ctr_d    [N];

    logic                run;
    logic [IDX_BITS-1:0] l_idx;
    logic [TAG_W-1:0]    l_tag;
    logic                l_hit;
    logic                l_taken;
    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_W-1:0]    u_tag;
    logic                u_hit;
    logic                u_accept;

    assign run = (state_q == S_RUN);

    // Lookup sees only registered table contents: no update bypass.
    always_comb begin
        l_idx   = IF_pc[IDX_BITS-1:0];
        l_tag   = IF_pc[WORD_SIZE-1:IDX_BITS];
        l_hit   = run && valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        l_taken = l_hit && (uncond_q[l_idx] || ctr_q[l_idx][1]);
    end

    assign pred_hit     = l_hit;
    assign pred_taken   = l_taken;
    assign predicted_pc = l_taken ? target_q[l_idx] : IF_pc + PC_ONE;
    assign ready        = ready_q;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == S_INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (&sweep_q) begin
                state_d = S_RUN;
            end
        end
        ready_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        u_idx    = upd_pc[IDX_BITS-1:0];
        u_tag    = upd_pc[WORD_SIZE-1:IDX_BITS];
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_accept = 1'b0;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        uncond_d = uncond_q;
        ctr_d    = ctr_q;
        if (state_q == S_INIT) begin
            valid_d[sweep_q]  = 1'b0;
            uncond_d[sweep_q] = 1'b0;
            ctr_d[sweep_q]    = 2'b01;
        end else if (upd_en) begin
            case (upd_kind)
                2'd1, 2'd2: begin
                    u_accept        = 1'b1;
                    valid_d[u_idx]  = 1'b1;
                    tag_d[u_idx]    = u_tag;
                    target_d[u_idx] = upd_target;
                    uncond_d[u_idx] = 1'b1;
                    ctr_d[u_idx]    = 2'b11;
                end
                2'd3: begin
                    if (u_hit) begin
                        u_accept        = 1'b1;
                        uncond_d[u_idx] = 1'b0;
                        if (upd_taken) begin
                            target_d[u_idx] = upd_target;
                            if (ctr_q[u_idx] != 2'b11) begin
                                ctr_d[u_idx] = ctr_q[u_idx] + 2'b01;
                            end
                        end else if (ctr_q[u_idx] != 2'b00) begin
                            ctr_d[u_idx] = ctr_q[u_idx] - 2'b01;
                        end
                    end else if (upd_taken) begin
                        u_accept        = 1'b1;
                        valid_d[u_idx]  = 1'b1;
                        tag_d[u_idx]    = u_tag;
                        target_d[u_idx] = upd_target;
                        uncond_d[u_idx] = 1'b0;
                        ctr_d[u_idx]    = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table is cleared by the sweep, so it needs no reset of its own.
    always_ff @(posedge clk) begin
        valid_q  <= valid_d;
        tag_q    <= tag_d;
        target_q <= target_d;
        uncond_q <= uncond_d;
        ctr_q    <= ctr_d;
    end

`ifdef BTB_STATS_EN
    logic [15:0] hits_q, hits_d;
    logic [15:0] upds_q, upds_d;

    always_comb begin
        hits_d = hits_q;
        upds_d = upds_q;
        if (fetch_en && l_hit && (hits_q != 16'hFFFF)) begin
            hits_d = hits_q + 16'd1;
        end
        if (u_accept && (upds_q != 16'hFFFF)) begin
            upds_d = upds_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q <= '0;
            upds_q <= '0;
        end else begin
            hits_q <= hits_d;
            upds_q <= upds_d;
        end
    end

    assign stat_hits    = hits_q;
    assign stat_updates = upds_q;
`else
    logic stats_unused;
    assign stats_unused = fetch_en ^ u_accept;
    assign stat_hits    = '0;
    assign stat_updates = '0;
`endif

endmodule
